tft_frame_prefetch: RTL and testbench

Read client that sits directly upstream of the SDRAM read/write arbiter on its read port 1 (TFT43 display path). Walks a 480x272 RGB565 frame buffer in SDRAM in 4-word bursts using the arbiter's req/done handshake. Buffers the returned words in a small FIFO and hands single pixels to the TFT timing/driver stage on demand, one word per pixel request.

---
 rtl/tft_frame_prefetch.sv | 188 ++++++++++++++++++
 tb/tb_tft_frame_prefetch.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tft_frame_prefetch.sv
// Frame-buffer read client: walks the frame in 4-word SDRAM bursts through the
// arbiter read port and serves single RGB565 pixels from a small FIFO.
module tft_frame_prefetch #(
  parameter int unsigned H_ACT      = 480,
  parameter int unsigned V_ACT      = 272,
  parameter logic [23:0] BASE_ADDR  = 24'h000000,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        iFrameStart,
  output logic                        oRd_Req,
  output logic [23:0]                 oRd_Addr,
  input  logic                        iRd_Done,
  input  logic [15:0]                 iRd_Data1,
  input  logic [15:0]                 iRd_Data2,
  input  logic [15:0]                 iRd_Data3,
  input  logic [15:0]                 iRd_Data4,
  input  logic                        iPixReq,
  output logic [15:0]                 oPixData,
  output logic                        oPixValid,
  output logic                        oUnderflow,
  output logic [$clog2(FIFO_DEPTH):0] oFifoLevel
);

  localparam int unsigned   AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned   LW        = AW + 1;
  localparam logic [23:0]   FW_LAST   = 24'(H_ACT * V_ACT - 4);
  localparam logic [LW-1:0] SPACE_THR = LW'(FIFO_DEPTH - 4);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_PUSH = 2'd2
  } state_t;

  state_t        state_r;
  logic          rd_req_r;
  logic [23:0]   rd_addr_r;
  logic [23:0]   ctr_r;
  logic          drop_r;
  logic [1:0]    push_idx_r;
  logic [15:0]   stage_r [4];

  logic [15:0]   mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic [15:0]   pix_data_r;
  logic          pix_valid_r;
  logic          underflow_r;

  logic          empty_s;
  logic          has_space_s;
  logic          push_s;
  logic          pop_s;
  logic [15:0]   push_word_s;
  logic [23:0]   ctr_next_s;

  // FIFO handshake qualifiers and next burst offset
  always_comb begin
    empty_s     = (level_r == LW'(0));
    has_space_s = (level_r <= SPACE_THR);
    push_s      = (state_r == ST_PUSH) && !iFrameStart;
    pop_s       = iPixReq && !empty_s && !iFrameStart;
    push_word_s = stage_r[push_idx_r];
    if (ctr_r == FW_LAST) begin
      ctr_next_s = 24'd0;
    end else begin
      ctr_next_s = ctr_r + 24'd4;
    end
  end

  // Burst fetch state machine: request, capture, replay into the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      rd_req_r   <= 1'b0;
      rd_addr_r  <= BASE_ADDR;
      ctr_r      <= 24'd0;
      drop_r     <= 1'b0;
      push_idx_r <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        stage_r[i] <= 16'd0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!iFrameStart && has_space_s) begin
            state_r   <= ST_REQ;
            rd_req_r  <= 1'b1;
            rd_addr_r <= BASE_ADDR + ctr_r;
          end
        end
        ST_REQ: begin
          if (iRd_Done) begin
            rd_req_r   <= 1'b0;
            stage_r[0] <= iRd_Data1;
            stage_r[1] <= iRd_Data2;
            stage_r[2] <= iRd_Data3;
            stage_r[3] <= iRd_Data4;
            drop_r     <= 1'b0;
            // A burst from before the last frame start is stale: discard it
            // and keep the counter rewound.
            if (drop_r || iFrameStart) begin
              state_r <= ST_IDLE;
            end else begin
              state_r    <= ST_PUSH;
              push_idx_r <= 2'd0;
              ctr_r      <= ctr_next_s;
            end
          end else if (iFrameStart) begin
            drop_r <= 1'b1;
          end
        end
        ST_PUSH: begin
          if (iFrameStart || push_idx_r == 2'd3) begin
            state_r    <= ST_IDLE;
            push_idx_r <= 2'd0;
          end else begin
            push_idx_r <= push_idx_r + 2'd1;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          rd_req_r <= 1'b0;
          drop_r   <= 1'b0;
        end
      endcase
      if (iFrameStart) begin
        ctr_r <= 24'd0;
      end
    end
  end

  // FIFO pointers, occupancy, sticky underflow and registered pop output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      level_r     <= '0;
      pix_data_r  <= 16'd0;
      pix_valid_r <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      pix_valid_r <= pop_s;
      if (pop_s) begin
        pix_data_r <= mem_r[rd_ptr_r];
      end
      if (iFrameStart) begin
        wr_ptr_r    <= '0;
        rd_ptr_r    <= '0;
        level_r     <= '0;
        underflow_r <= 1'b0;
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + AW'(1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + AW'(1);
        end
        case ({push_s, pop_s})
          2'b10:   level_r <= level_r + LW'(1);
          2'b01:   level_r <= level_r - LW'(1);
          default: level_r <= level_r;
        endcase
        if (iPixReq && empty_s) begin
          underflow_r <= 1'b1;
        end
      end
    end
  end

  // Pixel storage; contents are meaningless until written, so no reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_word_s;
    end
  end

  assign oRd_Req    = rd_req_r;
  assign oRd_Addr   = rd_addr_r;
  assign oPixData   = pix_data_r;
  assign oPixValid  = pix_valid_r;
  assign oUnderflow = underflow_r;
  assign oFifoLevel = level_r;

endmodule

// File: tb/tb_tft_frame_prefetch.sv
// Directed bench for tft_frame_prefetch: full-size instance plus a tiny-frame
// instance whose base sits at the top of the 24-bit space to exercise the wrap.
`timescale 1ns/1ps
module tb_tft_frame_prefetch;

  logic        clk;
  logic        rst_n;
  logic        frame_start;
  logic        pix_req;

  logic        rd_req, rd_done;
  logic [23:0] rd_addr;
  logic [15:0] rd_d1, rd_d2, rd_d3, rd_d4;
  logic [15:0] pix_data;
  logic        pix_valid, underflow;
  logic [4:0]  level;

  logic        w_req, w_done;
  logic [23:0] w_addr;
  logic [15:0] w_d1, w_d2, w_d3, w_d4;
  logic [15:0] w_pix_data;
  logic        w_pix_valid, w_underflow;
  logic [4:0]  w_level;

  int          n_chk = 0;
  int          n_err = 0;
  int          arb_lat = 10;
  logic [23:0] addr_log[$];
  logic [23:0] w_log[$];

  tft_frame_prefetch dut (
    .clk(clk), .rst_n(rst_n), .iFrameStart(frame_start),
    .oRd_Req(rd_req), .oRd_Addr(rd_addr), .iRd_Done(rd_done),
    .iRd_Data1(rd_d1), .iRd_Data2(rd_d2), .iRd_Data3(rd_d3), .iRd_Data4(rd_d4),
    .iPixReq(pix_req), .oPixData(pix_data), .oPixValid(pix_valid),
    .oUnderflow(underflow), .oFifoLevel(level)
  );

  tft_frame_prefetch #(.H_ACT(8), .V_ACT(1), .BASE_ADDR(24'hFFFFFC), .FIFO_DEPTH(16)) dut_w (
    .clk(clk), .rst_n(rst_n), .iFrameStart(1'b0),
    .oRd_Req(w_req), .oRd_Addr(w_addr), .iRd_Done(w_done),
    .iRd_Data1(w_d1), .iRd_Data2(w_d2), .iRd_Data3(w_d3), .iRd_Data4(w_d4),
    .iPixReq(1'b0), .oPixData(w_pix_data), .oPixValid(w_pix_valid),
    .oUnderflow(w_underflow), .oFifoLevel(w_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Arbiter model for the main instance: done arb_lat cycles after req, data = address
  initial begin
    int lat_cnt;
    lat_cnt = 0;
    rd_done = 1'b0;
    rd_d1 = 16'd0; rd_d2 = 16'd0; rd_d3 = 16'd0; rd_d4 = 16'd0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        rd_done = 1'b0; lat_cnt = 0; addr_log.delete();
      end else if (rd_done) begin
        rd_done = 1'b0; lat_cnt = 0;
      end else if (rd_req) begin
        lat_cnt++;
        if (lat_cnt >= arb_lat) begin
          rd_done = 1'b1;
          rd_d1 = rd_addr[15:0];
          rd_d2 = rd_addr[15:0] + 16'd1;
          rd_d3 = rd_addr[15:0] + 16'd2;
          rd_d4 = rd_addr[15:0] + 16'd3;
          addr_log.push_back(rd_addr);
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  // Arbiter model for the tiny-frame instance, fixed latency 3
  initial begin
    int lat_cnt;
    lat_cnt = 0;
    w_done = 1'b0;
    w_d1 = 16'd0; w_d2 = 16'd0; w_d3 = 16'd0; w_d4 = 16'd0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        w_done = 1'b0; lat_cnt = 0; w_log.delete();
      end else if (w_done) begin
        w_done = 1'b0; lat_cnt = 0;
      end else if (w_req) begin
        lat_cnt++;
        if (lat_cnt >= 3) begin
          w_done = 1'b1;
          w_d1 = w_addr[15:0];
          w_d2 = w_addr[15:0] + 16'd1;
          w_d3 = w_addr[15:0] + 16'd2;
          w_d4 = w_addr[15:0] + 16'd3;
          w_log.push_back(w_addr);
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic        ok;
    logic        pend;
    logic [31:0] exp_word;

    rst_n = 1'b0;
    frame_start = 1'b0;
    pix_req = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_req",       32'(rd_req),     32'd0);
    check("rst_addr",      32'(rd_addr),    32'h000000);
    check("rst_pix_data",  32'(pix_data),   32'd0);
    check("rst_pix_valid", 32'(pix_valid),  32'd0);
    check("rst_underflow", 32'(underflow),  32'd0);
    check("rst_level",     32'(level),      32'd0);
    check("rst_w_addr",    32'(w_addr),     32'hFFFFFC);

    // Pop on empty FIFO right after reset release
    rst_n = 1'b1;
    @(negedge clk); pix_req = 1'b1;
    @(negedge clk); pix_req = 1'b0;
    check("empty_pop_valid", 32'(pix_valid), 32'd0);
    check("empty_pop_uflow", 32'(underflow), 32'd1);
    check("empty_pop_level", 32'(level),     32'd0);
    @(negedge clk);
    check("uflow_sticky",    32'(underflow), 32'd1);
    frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    check("uflow_clr",       32'(underflow), 32'd0);
    check("fs_req_held",     32'(rd_req),    32'd1);
    check("fs_addr_held",    32'(rd_addr),   32'h000000);

    // Asynchronous reset in the middle of an outstanding burst
    rst_n = 1'b0;
    #1;
    check("ar_req",   32'(rd_req),  32'd0);
    check("ar_addr",  32'(rd_addr), 32'h000000);
    check("ar_level", 32'(level),   32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Fill with no pops: four bursts, then requests stop
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (level == 5'd16 && !rd_req) begin
        ok = 1'b1;
        break;
      end
    end
    check("fill_timeout", 32'(ok), 32'd1);
    repeat (30) @(negedge clk);
    check("fill_level",  32'(level),            32'd16);
    check("fill_req",    32'(rd_req),           32'd0);
    check("fill_bursts", 32'(addr_log.size()),  32'd4);
    check("fill_addr0",  32'(addr_log[0]),      32'h000000);
    check("fill_addr1",  32'(addr_log[1]),      32'h000004);
    check("fill_addr2",  32'(addr_log[2]),      32'h000008);
    check("fill_addr3",  32'(addr_log[3]),      32'h00000C);

    // Tiny frame (8 words) at the top of the address space wraps twice
    check("wrap_bursts", 32'(w_log.size()), 32'd4);
    check("wrap_addr0",  32'(w_log[0]),     32'hFFFFFC);
    check("wrap_addr1",  32'(w_log[1]),     32'h000000);
    check("wrap_addr2",  32'(w_log[2]),     32'hFFFFFC);
    check("wrap_addr3",  32'(w_log[3]),     32'h000000);
    check("wrap_level",  32'(w_level),      32'd16);
    check("wrap_req",    32'(w_req),        32'd0);

    // Back-to-back pops from a full FIFO, latency 8
    arb_lat = 8;
    pix_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 15) pix_req = 1'b0;
      check("b2b_valid", 32'(pix_valid), 32'd1);
      check("b2b_data",  32'(pix_data),  32'(i));
    end
    check("b2b_uflow", 32'(underflow), 32'd0);

    // Paced pops (one per 4 cycles) until the request at 0x40 appears
    exp_word = 32'd16;
    pend = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (pend) begin
        check("paced_valid", 32'(pix_valid), 32'd1);
        check("paced_data",  32'(pix_data),  exp_word);
        exp_word = exp_word + 32'd1;
        pend = 1'b0;
      end
      if (rd_req && rd_addr == 24'h000040) begin
        ok = 1'b1;
        pix_req = 1'b0;
        break;
      end
      pix_req = ((c % 4) == 0);
      pend = pix_req;
    end
    check("req40_seen",  32'(ok),        32'd1);
    check("paced_uflow", 32'(underflow), 32'd0);

    // Frame start while the 0x40 burst is outstanding
    frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
    check("fs40_req",   32'(rd_req),  32'd1);
    check("fs40_addr",  32'(rd_addr), 32'h000040);
    check("fs40_level", 32'(level),   32'd0);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (!rd_req) begin
        ok = 1'b1;
        break;
      end
      check("fs40_addr_hold", 32'(rd_addr), 32'h000040);
    end
    check("fs40_done_seen",  32'(ok),        32'd1);
    check("fs40_drop_level", 32'(level),     32'd0);
    check("fs40_drop_valid", 32'(pix_valid), 32'd0);
    @(negedge clk);
    check("fs40_next_req",   32'(rd_req),    32'd1);
    check("fs40_next_addr",  32'(rd_addr),   32'h000000);

    // Push/pop overlap: level reaches 5 on the first push of the second burst
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (level == 5'd5) begin
        ok = 1'b1;
        break;
      end
    end
    check("ov_level5_seen", 32'(ok), 32'd1);
    pix_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 2) pix_req = 1'b0;
      check("ov_level", 32'(level),     32'd5);
      check("ov_valid", 32'(pix_valid), 32'd1);
      check("ov_data",  32'(pix_data),  32'(i));
    end
    @(negedge clk);
    check("ov_after_level", 32'(level),     32'd5);
    check("ov_after_valid", 32'(pix_valid), 32'd0);
    check("ov_after_data",  32'(pix_data),  32'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
